// File: rtl/hog_pkg.sv
// Shared pixel definitions and sizing helpers for the sliding-window blocks.
package hog_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] pixel_t;

    function automatic int col_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_row_shift.sv
// One window row: DEPTH-deep pixel shifter; column 0 holds the oldest pixel.
module window_row_shift #(
    parameter int DEPTH = 3,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic [DW-1:0]       din,
    output logic [DEPTH*DW-1:0] win_next
);

    logic [DEPTH-1:0][DW-1:0] win_q;
    logic [DEPTH-1:0][DW-1:0] win_d;

    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int c = 0; c < DEPTH - 1; c++) begin
                win_d[c] = win_q[c+1];
            end
            win_d[DEPTH-1] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    // The top registers the post-shift view so the window includes the column just accepted.
    assign win_next = win_d;

endmodule

// File: rtl/stride_kernel.sv
// Sliding BLOCK_WIDTH x BLOCK_HEIGHT window over a column stream, emitting every STRIDE-th window per line.
module stride_kernel
    import hog_pkg::*;
#(
    parameter int BLOCK_WIDTH  = 3,
    parameter int BLOCK_HEIGHT = 3,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
    parameter int IMAGE_WIDTH  = 64,
    parameter int STRIDE       = 1,
    localparam int CW          = col_width(IMAGE_WIDTH)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [DATA_WIDTH*BLOCK_HEIGHT-1:0]         in_pixels,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic [BLOCK_WIDTH*BLOCK_HEIGHT*DATA_WIDTH-1:0] out_pixels,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [CW-1:0]                              out_col,
    output logic                                       out_eol
);

    localparam int SW       = col_width(STRIDE);
    localparam int WIN_W    = BLOCK_WIDTH * DATA_WIDTH;
    localparam int PIX_W    = BLOCK_HEIGHT * WIN_W;
    localparam int LAST_COL = BLOCK_WIDTH - 1 + ((IMAGE_WIDTH - BLOCK_WIDTH) / STRIDE) * STRIDE;

    localparam logic [CW-1:0] COL_FIRST     = CW'(BLOCK_WIDTH - 1);
    localparam logic [CW-1:0] COL_MAX       = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] COL_LAST      = CW'(LAST_COL);
    localparam logic [SW-1:0] STRIDE_RELOAD = SW'(STRIDE - 1);

    logic             push;
    logic             produce;
    logic [PIX_W-1:0] win_next;

    logic [CW-1:0]    col_q, col_d;
    logic [SW-1:0]    stride_q, stride_d;
    logic             out_valid_q, out_valid_d;
    logic             out_eol_q, out_eol_d;
    logic [CW-1:0]    out_col_q, out_col_d;
    logic [PIX_W-1:0] out_pixels_q, out_pixels_d;

    for (genvar r = 0; r < BLOCK_HEIGHT; r++) begin : g_row
        window_row_shift #(
            .DEPTH (BLOCK_WIDTH),
            .DW    (DATA_WIDTH)
        ) u_row (
            .clk      (clk),
            .rst      (rst),
            .shift_en (push),
            .din      (in_pixels[r*DATA_WIDTH +: DATA_WIDTH]),
            .win_next (win_next[r*WIN_W +: WIN_W])
        );
    end

    assign in_ready = !out_valid_q || out_ready;
    assign push     = in_valid && in_ready;
    assign produce  = push && (col_q >= COL_FIRST) && (stride_q == '0);

    always_comb begin
        col_d        = col_q;
        stride_d     = stride_q;
        out_valid_d  = out_valid_q;
        out_eol_d    = out_eol_q;
        out_col_d    = out_col_q;
        out_pixels_d = out_pixels_q;

        if (push) begin
            col_d = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
            // Stride phase only runs once a full window exists and restarts each line.
            if (col_q == COL_MAX || col_q < COL_FIRST) begin
                stride_d = '0;
            end else if (stride_q == '0) begin
                stride_d = STRIDE_RELOAD;
            end else begin
                stride_d = stride_q - SW'(1);
            end
        end

        if (produce) begin
            out_valid_d  = 1'b1;
            out_pixels_d = win_next;
            out_col_d    = col_q;
            out_eol_d    = (col_q == COL_LAST);
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q        <= '0;
            stride_q     <= '0;
            out_valid_q  <= 1'b0;
            out_eol_q    <= 1'b0;
            out_col_q    <= '0;
            out_pixels_q <= '0;
        end else begin
            col_q        <= col_d;
            stride_q     <= stride_d;
            out_valid_q  <= out_valid_d;
            out_eol_q    <= out_eol_d;
            out_col_q    <= out_col_d;
            out_pixels_q <= out_pixels_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_eol    = out_eol_q;
    assign out_col    = out_col_q;
    assign out_pixels = out_pixels_q;

endmodule

// File: tb/tb_stride_kernel.sv
// Directed bench: three kernels (STRIDE 1,2,3) on 8-pixel lines with a 3x3 window.
module tb_stride_kernel;

    localparam int BW = 3;
    localparam int BH = 3;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int PW = BW * BH * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst        [3];
    logic [DW*BH-1:0] in_pixels [3];
    logic           in_valid   [3];
    logic           in_ready   [3];
    logic [PW-1:0]  out_pixels [3];
    logic           out_valid  [3];
    logic           out_ready  [3];
    logic [2:0]     out_col    [3];
    logic           out_eol    [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        stride_kernel #(
            .BLOCK_WIDTH  (BW),
            .BLOCK_HEIGHT (BH),
            .DATA_WIDTH   (DW),
            .IMAGE_WIDTH  (IW),
            .STRIDE       (g + 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .in_pixels  (in_pixels[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .out_pixels (out_pixels[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_col    (out_col[g]),
            .out_eol    (out_eol[g])
        );
    end

    typedef struct {
        int            col;
        logic          eol;
        logic [PW-1:0] pix;
    } win_t;

    win_t got[$];
    win_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int   m_col;
    int   m_h0, m_h1, m_h2;
    logic obs_ir, obs_ov;
    logic [PW-1:0] obs_pix;

    // Row r of a column carries val + 64*r so row mix-ups are visible.
    function automatic logic [DW*BH-1:0] mk(input int val);
        logic [DW*BH-1:0] p;
        for (int r = 0; r < BH; r++) p[r*DW +: DW] = DW'(val + 64 * r);
        return p;
    endfunction

    function automatic logic [PW-1:0] mkwin(input int a, input int b, input int c);
        logic [PW-1:0] p;
        for (int r = 0; r < BH; r++) begin
            p[(r*BW+0)*DW +: DW] = DW'(a + 64 * r);
            p[(r*BW+1)*DW +: DW] = DW'(b + 64 * r);
            p[(r*BW+2)*DW +: DW] = DW'(c + 64 * r);
        end
        return p;
    endfunction

    task automatic model_reset();
        m_col = 0; m_h0 = 0; m_h1 = 0; m_h2 = 0;
        got.delete(); exp_q.delete();
    endtask

    task automatic model_push(input int s, input int val);
        win_t w;
        m_h0 = m_h1; m_h1 = m_h2; m_h2 = val;
        if (m_col >= BW - 1 && ((m_col - (BW - 1)) % s) == 0) begin
            w.col = m_col;
            w.eol = (m_col + s > IW - 1);
            w.pix = mkwin(m_h0, m_h1, m_h2);
            exp_q.push_back(w);
        end
        m_col = (m_col + 1) % IW;
    endtask

    task automatic cycle(input int k, input logic v, input int val, input logic ordy, output logic xfer);
        win_t w;
        in_valid[k]  = v;
        in_pixels[k] = mk(val);
        out_ready[k] = ordy;
        @(negedge clk);
        obs_ir  = in_ready[k];
        obs_ov  = out_valid[k];
        obs_pix = out_pixels[k];
        if (out_valid[k] && ordy) begin
            w.col = int'(out_col[k]); w.eol = out_eol[k]; w.pix = out_pixels[k];
            got.push_back(w);
        end
        xfer = v && in_ready[k];
        if (xfer) model_push(k + 1, val);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int k);
        logic x;
        for (int i = 0; i < 3; i++) cycle(k, 1'b0, 0, 1'b1, x);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1; in_pixels[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (out_valid[k] !== 1'b0 || out_col[k] !== 3'd0 || out_eol[k] !== 1'b0 || out_pixels[k] !== '0) begin
                bad++;
                $display("FAIL reset_state dut%0d: valid=%b col=%0d eol=%b pix=%h, want all zero",
                         k, out_valid[k], out_col[k], out_eol[k], out_pixels[k]);
            end
            rst[k] = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (in_ready[k] !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready dut%0d: got %b want 1", k, in_ready[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stride1();
        logic x;
        model_reset();
        for (int v = 0; v < IW; v++) cycle(0, 1'b1, v, 1'b1, x);
        drain(0);
        total++;
        if (got.size() !== 6) begin bad++; $display("FAIL s1_count: got %0d want 6", got.size()); end
        total++;
        if (got.size() > 0 && got[0].pix !== mkwin(0, 1, 2)) begin
            bad++; $display("FAIL s1_first_window: got %h want %h", got[0].pix, mkwin(0, 1, 2));
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i].col !== 2 + i || got[i].eol !== (i == 5) || got[i].pix !== exp_q[i].pix) begin
                bad++;
                $display("FAIL s1_win%0d: col=%0d eol=%b pix=%h want col=%0d eol=%b pix=%h",
                         i, got[i].col, got[i].eol, got[i].pix, 2 + i, (i == 5), exp_q[i].pix);
            end
        end
    endtask

    task automatic test_stride2();
        logic x;
        logic ir_all;
        model_reset();
        ir_all = 1'b1;
        for (int v = 0; v < IW; v++) begin
            cycle(1, 1'b1, v, 1'b1, x);
            ir_all = ir_all & obs_ir;
        end
        drain(1);
        total++;
        if (ir_all !== 1'b1) begin bad++; $display("FAIL s2_in_ready: dropped low, want always 1"); end
        total++;
        if (got.size() !== 3) begin bad++; $display("FAIL s2_count: got %0d want 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            total++;
            if (got[i].col !== 2 + 2 * i || got[i].eol !== (i == 2) ||
                got[i].pix !== mkwin(2 * i, 2 * i + 1, 2 * i + 2)) begin
                bad++;
                $display("FAIL s2_win%0d: col=%0d eol=%b pix=%h want col=%0d eol=%b",
                         i, got[i].col, got[i].eol, got[i].pix, 2 + 2 * i, (i == 2));
            end
        end
    endtask

    task automatic test_stall();
        logic x;
        int   v;
        int   guard;
        model_reset();
        for (int c = 0; c < 3; c++) cycle(0, 1'b1, c, 1'b1, x);
        for (int s = 0; s < 4; s++) begin
            cycle(0, 1'b1, 3, 1'b0, x);
            total++;
            if (obs_ir !== 1'b0 || obs_ov !== 1'b1 || obs_pix !== mkwin(0, 1, 2)) begin
                bad++;
                $display("FAIL stall_hold%0d: in_ready=%b valid=%b pix=%h want 0 1 %h",
                         s, obs_ir, obs_ov, obs_pix, mkwin(0, 1, 2));
            end
        end
        v = 3; guard = 0;
        while (v < IW && guard < 50) begin
            cycle(0, 1'b1, v, 1'b1, x);
            if (x) v++;
            guard++;
        end
        total++;
        if (v != IW) begin bad++; $display("FAIL stall_progress: accepted %0d want %0d", v, IW); end
        drain(0);
        total++;
        if (got.size() !== 6 || exp_q.size() !== 6) begin
            bad++; $display("FAIL stall_count: got %0d want 6", got.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i].col !== exp_q[i].col || got[i].eol !== exp_q[i].eol || got[i].pix !== exp_q[i].pix) begin
                bad++;
                $display("FAIL stall_win%0d: col=%0d pix=%h want col=%0d pix=%h",
                         i, got[i].col, got[i].pix, exp_q[i].col, exp_q[i].pix);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic x;
        model_reset();
        for (int v = 0; v < IW; v++) cycle(0, 1'b1, v, 1'b1, x);
        for (int v = 10; v < 10 + IW; v++) cycle(0, 1'b1, v, 1'b1, x);
        drain(0);
        total++;
        if (got.size() !== 12) begin bad++; $display("FAIL b2b_count: got %0d want 12", got.size()); end
        total++;
        if (got.size() > 6 && (got[6].col !== 2 || got[6].pix !== mkwin(10, 11, 12))) begin
            bad++;
            $display("FAIL b2b_line2_first: col=%0d pix=%h want col=2 pix=%h", got[6].col, got[6].pix, mkwin(10, 11, 12));
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i].col !== exp_q[i].col || got[i].eol !== exp_q[i].eol || got[i].pix !== exp_q[i].pix) begin
                bad++;
                $display("FAIL b2b_win%0d: col=%0d eol=%b pix=%h want col=%0d eol=%b pix=%h",
                         i, got[i].col, got[i].eol, got[i].pix, exp_q[i].col, exp_q[i].eol, exp_q[i].pix);
            end
        end
    endtask

    task automatic test_reset_midline();
        logic x;
        logic early_valid;
        model_reset();
        for (int v = 0; v < 6; v++) cycle(0, 1'b1, v, 1'b0, x);
        in_valid[0] = 1'b0; out_ready[0] = 1'b0; rst[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        total++;
        if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", out_valid[0]); end
        model_reset();
        early_valid = 1'b0;
        for (int v = 20; v < 20 + IW; v++) begin
            cycle(0, 1'b1, v, 1'b1, x);
            if (v <= 22) early_valid = early_valid | obs_ov;
        end
        drain(0);
        total++;
        if (early_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_early: window before 3 new columns"); end
        total++;
        if (got.size() !== 6 || got[0].col !== 2 || got[0].pix !== mkwin(20, 21, 22)) begin
            bad++;
            $display("FAIL mid_reset_first: n=%0d col=%0d pix=%h want n=6 col=2 pix=%h",
                     got.size(), (got.size() > 0) ? got[0].col : -1, (got.size() > 0) ? got[0].pix : '0, mkwin(20, 21, 22));
        end
    endtask

    task automatic test_random();
        logic x;
        int   v;
        int   guard;
        model_reset();
        v = 0; guard = 0;
        while (v < 4 * IW && guard < 2000) begin
            cycle(2, 1'($urandom_range(0, 1)), (v / IW) * 10 + (v % IW), 1'($urandom_range(0, 1)), x);
            if (x) v++;
            guard++;
        end
        total++;
        if (v != 4 * IW) begin bad++; $display("FAIL rand_progress: accepted %0d want %0d", v, 4 * IW); end
        drain(2);
        total++;
        if (got.size() !== 8 || exp_q.size() !== 8) begin
            bad++; $display("FAIL rand_count: got %0d want 8", got.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i].col !== ((i % 2) ? 5 : 2) || got[i].eol !== exp_q[i].eol || got[i].pix !== exp_q[i].pix) begin
                bad++;
                $display("FAIL rand_win%0d: col=%0d eol=%b pix=%h want col=%0d eol=%b pix=%h",
                         i, got[i].col, got[i].eol, got[i].pix, (i % 2) ? 5 : 2, exp_q[i].eol, exp_q[i].pix);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stride1();
        test_stride2();
        test_stall();
        test_back_to_back();
        test_reset_midline();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
